gray_seq_ctrl: RTL and testbench
================================

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CLR, default 0; 1 = out returns to 4'b0000 on the cycle after done.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 SHALL have port start  input  1  request to run a sequence; sampled only in IDLE.
REQ-005 SHALL have port dir  input  1  0 = forward Gray order, 1 = reverse; latched with start.
REQ-006 SHALL have port len  input  4  step count; 0 means 16; latched with start.
REQ-007 SHALL have port hold  input  1  pause stepping while 1; ignored in IDLE.
REQ-008 SHALL have port out  output  4  current 4-bit reflected Gray code, registered.
REQ-009 SHALL have port busy  output  1  1 in RUN or PAUSE.
REQ-010 SHALL have port paused  output  1  1 in PAUSE only.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the final step is taken.

Function
REQ-012 SHALL step through the forward order 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, wrapping 1000->0000.
REQ-013 SHALL step in reverse order when dir=1, wrapping 0000->1000.
REQ-014 SHALL implement the states IDLE, RUN and PAUSE; the state register is internal and is not a port.
REQ-015 SHALL, in IDLE with start=1 at posedge k, latch dir and len (0 -> 16) into a 5-bit remaining counter, enter RUN and leave out unchanged at k.
REQ-016 SHALL, in RUN with hold=0, advance out by one step per posedge and decrement remaining by 1.
REQ-017 SHALL, in RUN or PAUSE with hold=1, take no step and be in PAUSE after that edge; with hold=0 in PAUSE it SHALL return to RUN and step on that same edge.
REQ-018 SHALL, on the edge where remaining goes 1->0, present the final code, assert done for exactly one cycle, drop busy and enter IDLE.
REQ-019 SHALL ignore start while busy=1: no relatch and no restart.
REQ-020 SHALL accept start in the cycle where done=1, because the state is then IDLE.
REQ-021 SHALL hold out stable in IDLE, except when IDLE_CLR=1: out <= 0000 on the edge after done.
REQ-022 SHALL continue stepping from the current out value across successive runs; there is no implicit return to 0000.

Reset
REQ-023 SHALL, when reset=0, immediately and asynchronously set out=0000, busy=0, paused=0, done=0, remaining=0 and state=IDLE, including in the middle of a run.
REQ-024 SHALL hold these reset values while reset=0 and act on the first posedge after reset=1.

Configuration
REQ-025 SHALL, with GRAY_SEQ_CTRL_IDX_EN defined, add port idx  output  4, the binary position of out in the forward order (0000->0, 1000->15); its reset value SHALL be 0 and it SHALL update on the same edge as out.
REQ-026 SHALL, with GRAY_SEQ_CTRL_IDX_EN undefined, omit idx and its logic entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover: after reset, start=1, dir=0, len=3 -> out 0001, 0011, 0010 on the next three edges; done=1 with out=0010; busy=0 afterwards.
REQ-028 SHALL cover: from out=0000, start, dir=1, len=2 -> out 1000, then 1001; done with 1001 (reverse wrap).
REQ-029 SHALL cover: len=0 forward from 0000 -> 16 steps ending at 0000; done on the 16th step; idx=0 (if enabled).
REQ-030 SHALL cover: len=4, hold=1 for 3 cycles after the 1st step -> paused=1 for 3 cycles, out frozen at 0001; total 7 edges to done; start pulses during the run are ignored.
REQ-031 SHALL cover: reset=0 asserted between clock edges mid-run at out=0110 -> out=0000, busy=0 immediately, with no done pulse.
REQ-032 SHALL cover: start asserted in the done cycle -> a new run begins from the final code; with IDLE_CLR=1 and no start, out=0000 one edge after done.

Source files
------------

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a 4-bit reflected Gray code forward or backward
// for a latched number of steps, with pause (hold) and a done pulse.
//
// Ports:
//   clk     - clock, all state changes on posedge
//   reset   - asynchronous active-low reset
//   start   - run request, sampled only in IDLE
//   dir     - 0 forward Gray order, 1 reverse; latched with start
//   len     - step count, 0 means 16; latched with start
//   hold    - pause stepping while 1 (ignored in IDLE)
//   out     - current Gray code (registered)
//   busy    - 1 in RUN or PAUSE
//   paused  - 1 in PAUSE only
//   done    - one-cycle pulse after the final step
//   idx     - binary position of out (only with GRAY_SEQ_CTRL_IDX_EN)
//
// Parameter IDLE_CLR: 1 = out returns to 0000 on the edge after done.
// Optional feature macro: GRAY_SEQ_CTRL_IDX_EN adds the idx output.

module gray_seq_ctrl #(
    parameter bit IDLE_CLR = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [3:0] len,
    input  logic       hold,
    output logic [3:0] out,
    output logic       busy,
    output logic       paused,
`ifdef GRAY_SEQ_CTRL_IDX_EN
    output logic       done,
    output logic [3:0] idx
`else
    output logic       done
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    state_t     state;
    state_t     state_nx;
    logic [3:0] out_nx;
    logic [4:0] rem;
    logic [4:0] rem_nx;
    logic       dir_q;
    logic       dir_nx;
    logic       done_nx;
    logic [3:0] pos;
    logic [3:0] pos_step;

    // Stepping is done in the binary domain, which wraps naturally
    // at both ends of the Gray sequence.
    assign pos      = g2b(out);
    assign pos_step = dir_q ? (pos - 4'd1) : (pos + 4'd1);

    assign busy   = (state != IDLE);
    assign paused = (state == PAUSE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        out_nx   = out;
        rem_nx   = rem;
        dir_nx   = dir_q;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                // A start in the done cycle takes priority over the clear,
                // so the new run begins from the final code.
                if (start) begin
                    dir_nx   = dir;
                    rem_nx   = (len == 4'd0) ? 5'd16 : {1'b0, len};
                    state_nx = RUN;
                end else if (IDLE_CLR && done) begin
                    out_nx = 4'b0000;
                end
            end
            RUN, PAUSE: begin
                if (hold) begin
                    state_nx = PAUSE;
                end else begin
                    out_nx = b2g(pos_step);
                    rem_nx = rem - 5'd1;
                    if (rem == 5'd1) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out   <= 4'b0000;
            rem   <= 5'd0;
            dir_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            out   <= out_nx;
            rem   <= rem_nx;
            dir_q <= dir_nx;
            done  <= done_nx;
        end
    end

`ifdef GRAY_SEQ_CTRL_IDX_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= 4'd0;
        end else begin
            idx <= g2b(out_nx);
        end
    end
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and random stimulus against a position-
// based reference model, for IDLE_CLR=0 and IDLE_CLR=1 instances.

module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dir;
    logic [3:0] len;
    logic       hold;
    logic [3:0] out0, out1;
    logic       busy0, busy1;
    logic       paused0, paused1;
    logic       done0, done1;
`ifdef GRAY_SEQ_CTRL_IDX_EN
    logic [3:0] idx0, idx1;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gray_seq_ctrl #(.IDLE_CLR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .dir(dir),
        .len(len), .hold(hold), .out(out0), .busy(busy0),
        .paused(paused0),
`ifdef GRAY_SEQ_CTRL_IDX_EN
        .done(done0), .idx(idx0)
`else
        .done(done0)
`endif
    );

    gray_seq_ctrl #(.IDLE_CLR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .dir(dir),
        .len(len), .hold(hold), .out(out1), .busy(busy1),
        .paused(paused1),
`ifdef GRAY_SEQ_CTRL_IDX_EN
        .done(done1), .idx(idx1)
`else
        .done(done1)
`endif
    );

    // Forward Gray order as listed in the requirements.
    logic [3:0] gt [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010,
        4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110,
        4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    // Model: positions in the forward list, 0=idle 1=run 2=pause.
    int pos [2];
    int mode;
    int mrem;
    bit mdir;
    bit mdone;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos[0] = 0;
        pos[1] = 0;
        mode   = 0;
        mrem   = 0;
        mdir   = 1'b0;
        mdone  = 1'b0;
    endtask

    task automatic check_all();
        chk("out",    32'(out0),    32'(gt[pos[0]]));
        chk("outclr", 32'(out1),    32'(gt[pos[1]]));
        chk("busy",   32'(busy0),   32'(mode != 0));
        chk("busy1",  32'(busy1),   32'(mode != 0));
        chk("paused", 32'(paused0), 32'(mode == 2));
        chk("paused1",32'(paused1), 32'(mode == 2));
        chk("done",   32'(done0),   32'(mdone));
        chk("done1",  32'(done1),   32'(mdone));
`ifdef GRAY_SEQ_CTRL_IDX_EN
        chk("idx",    32'(idx0),    32'(pos[0]));
        chk("idx1",   32'(idx1),    32'(pos[1]));
`endif
    endtask

    // Called at a negedge; applies inputs across one posedge.
    task automatic step(input bit s, input bit d, input int l,
                        input bit h);
        bit ndone;
        start = s;
        dir   = d;
        len   = 4'(l);
        hold  = h;
        @(posedge clk);
        ndone = 1'b0;
        if (mode == 0) begin
            if (s) begin
                mdir = d;
                mrem = (l % 16 == 0) ? 16 : l % 16;
                mode = 1;
            end else if (mdone) begin
                pos[1] = 0;
            end
        end else if (h) begin
            mode = 2;
        end else begin
            for (int k = 0; k < 2; k++)
                pos[k] = (pos[k] + (mdir ? 15 : 1)) % 16;
            mrem--;
            if (mrem == 0) begin
                ndone = 1'b1;
                mode  = 0;
            end else begin
                mode = 1;
            end
        end
        mdone = ndone;
        @(negedge clk);
        check_all();
    endtask

    // Reset pulse between edges; outputs must clear immediately.
    task automatic areset();
        start = 1'b0;
        hold  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out",  32'(out0),   32'd0);
        chk("rst_out1", 32'(out1),   32'd0);
        chk("rst_busy", 32'(busy0),  32'd0);
        chk("rst_paus", 32'(paused0),32'd0);
        chk("rst_done", 32'(done0),  32'd0);
`ifdef GRAY_SEQ_CTRL_IDX_EN
        chk("rst_idx",  32'(idx0),   32'd0);
`endif
        model_reset();
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        len   = 4'd0;
        hold  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // Forward len=3: 0001, 0011, 0010 then done.
        step(1, 0, 3, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("fwd3_end", 32'(out0), 32'b0010);
        step(0, 0, 0, 0);

        // Reverse wrap from 0000, len=2.
        areset();
        step(1, 1, 2, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("rev_end", 32'(out0), 32'b1001);
        step(0, 0, 0, 0);

        // len=0 means 16 steps, back to 0000.
        areset();
        step(1, 0, 0, 0);
        repeat (16) step(0, 0, 0, 0);
        chk("len16_end", 32'(out0), 32'b0000);
        step(0, 0, 0, 0);

        // Hold for 3 cycles after first step, start pulses ignored.
        areset();
        step(1, 0, 4, 0);
        step(1, 1, 9, 0);
        repeat (3) step(1, 1, 7, 1);
        repeat (3) step(1, 1, 5, 0);
        step(0, 0, 0, 0);

        // Reset mid-run at 0110.
        areset();
        step(1, 0, 8, 0);
        repeat (4) step(0, 0, 0, 0);
        chk("mid_out", 32'(out0), 32'b0110);
        areset();
        step(0, 0, 0, 0);

        // Start in the done cycle, then idle clear.
        step(1, 0, 2, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 3, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(79) == 0)
                areset();
            else
                step($urandom_range(3) == 0, 1'($urandom),
                     int'($urandom_range(15)),
                     $urandom_range(4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
